// File: rtl/seg_scan.sv
//==============================================================================
// Module      : seg_scan
// Description : Three-digit multiplexed 7-segment scanner with per-slot
//               blanking, frame-synchronous double buffering and leading-zero
//               suppression. All outputs are registered.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seg_scan #(
    parameter int         DIV      = 1000,
    parameter int         BLANK    = 8,
    parameter logic [6:0] ZERO_PAT = 7'b0111111,
    parameter bit         SEG_INV  = 1'b1,
    parameter bit         DIG_INV  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load,
    input  logic [6:0] seg2,
    input  logic [6:0] seg1,
    input  logic [6:0] seg0,
    input  logic       lz_blank,
    output logic [6:0] seg,
    output logic [2:0] dig,
    output logic       frame_done
);

    localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]  SHOW_END = CW'(DIV - BLANK);
    localparam logic [6:0]     SEG_OFF  = SEG_INV ? 7'h7F : 7'h00;
    localparam logic [2:0]     DIG_OFF  = DIG_INV ? 3'h7 : 3'h0;

    typedef enum logic {
        SHOW = 1'b0,
        BLK  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic [1:0]      idx;
    logic [1:0]      idx_nx;
    logic [2:0][6:0] act;      // displayed patterns, [2]=hundreds
    logic [2:0][6:0] pbuf;     // pending patterns awaiting the next frame
    logic [2:0][6:0] act_nx;
    logic            pend;
    logic            started;  // cleared by reset; marks the first enabled edge
    logic            wrap;
    logic            frame_wrap;
    logic            xfer;
    logic            blank2;
    logic            blank1;
    logic [6:0]      pat_nx;
    logic [2:0]      dig_nx;

    // Next scan position, buffer transfer decision and the pattern to show.
    always_comb begin
        wrap       = (cnt == CNT_LAST);
        cnt_nx     = wrap ? '0 : cnt + CW'(1);
        idx_nx     = idx;
        if (wrap) begin
            idx_nx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        frame_wrap = wrap && (idx == 2'd2);
        state_nx   = (cnt_nx < SHOW_END) ? SHOW : BLK;
        // Transfer on entry into the units SHOW slot, or on the first
        // enabled edge after reset so a pre-loaded value appears at once.
        xfer       = pend && (!started ||
                     ((idx_nx == 2'd0) && (state_nx == SHOW) &&
                      !((idx == 2'd0) && (state == SHOW))));
        act_nx     = xfer ? pbuf : act;
        blank2     = lz_blank && (act_nx[2] == ZERO_PAT);
        blank1     = blank2 && (act_nx[1] == ZERO_PAT);
        case (idx_nx)
            2'd2:    pat_nx = blank2 ? 7'h00 : act_nx[2];
            2'd1:    pat_nx = blank1 ? 7'h00 : act_nx[1];
            default: pat_nx = act_nx[0];
        endcase
        dig_nx     = 3'b001 << idx_nx;
    end

    // Scan state machine, load capture and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= 2'd0;
            state      <= SHOW;
            act        <= '0;
            pbuf       <= '0;
            pend       <= 1'b0;
            started    <= 1'b0;
            frame_done <= 1'b0;
            seg        <= SEG_OFF;
            dig        <= DIG_OFF;
        end else begin
            // A load coinciding with a transfer keeps pend set: the
            // transfer takes the old pending data, the new data waits.
            if (load) begin
                pbuf <= {seg2, seg1, seg0};
                pend <= 1'b1;
            end else if (en && xfer) begin
                pend <= 1'b0;
            end

            if (en) begin
                cnt        <= cnt_nx;
                idx        <= idx_nx;
                state      <= state_nx;
                started    <= 1'b1;
                if (xfer) begin
                    act <= pbuf;
                end
                frame_done <= frame_wrap;
                if (state_nx == SHOW) begin
                    seg <= pat_nx ^ SEG_OFF;
                    dig <= dig_nx ^ DIG_OFF;
                end else begin
                    seg <= SEG_OFF;
                    dig <= DIG_OFF;
                end
            end else begin
                frame_done <= 1'b0;
                seg        <= SEG_OFF;
                dig        <= DIG_OFF;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan.sv
//==============================================================================
// Module      : tb_seg_scan
// Description : Scoreboard bench for seg_scan. A frame-position reference
//               model queues the expected outputs per cycle; a monitor pops
//               and compares them against a true-polarity and an inverted
//               instance.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seg_scan;

    localparam int         DIV   = 8;
    localparam int         BLANK = 2;
    localparam logic [6:0] ZP    = 7'h3F;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic       lz_blank = 1'b0;
    logic [6:0] seg2 = '0, seg1 = '0, seg0 = '0;
    logic [6:0] seg_a, seg_b;
    logic [2:0] dig_a, dig_b;
    logic       fd_a, fd_b;

    typedef struct {
        logic [6:0] seg;
        logic [2:0] dig;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   dut_fd = 0;
    int   m_fd   = 0;

    // Reference model: frame position 0..3*DIV-1 plus the two buffers.
    int         m_pos = 0;
    bit         m_started = 1'b0;
    bit         m_pend = 1'b0;
    logic [6:0] m_act[3];
    logic [6:0] m_pbuf[3];
    logic [6:0] cur2, cur1, cur0;
    bit         cur_lz = 1'b0;

    always #5 clk = ~clk;

    seg_scan #(.DIV(DIV), .BLANK(BLANK), .ZERO_PAT(ZP), .SEG_INV(1'b0), .DIG_INV(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .seg2(seg2), .seg1(seg1), .seg0(seg0), .lz_blank(lz_blank),
        .seg(seg_a), .dig(dig_a), .frame_done(fd_a)
    );

    seg_scan #(.DIV(DIV), .BLANK(BLANK), .ZERO_PAT(ZP), .SEG_INV(1'b1), .DIG_INV(1'b1)) u_inv (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .seg2(seg2), .seg1(seg1), .seg0(seg0), .lz_blank(lz_blank),
        .seg(seg_b), .dig(dig_b), .frame_done(fd_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push(input logic [6:0] s, input logic [2:0] d, input logic f);
        exp_t e;
        e.seg = s;
        e.dig = d;
        e.fd  = f;
        q.push_back(e);
        if (f) m_fd++;
    endtask

    task automatic model_reset();
        m_pos     = 0;
        m_started = 1'b0;
        m_pend    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_act[k]  = '0;
            m_pbuf[k] = '0;
        end
    endtask

    // One clock of stimulus, driven at the falling edge, with the expected
    // outputs after the following rising edge queued for the monitor.
    task automatic step(input bit e, input bit ld, input logic [6:0] a2,
                        input logic [6:0] a1, input logic [6:0] a0, input bit lz);
        int         np, i, c;
        logic [6:0] pat;
        bit         b2, b1;
        @(negedge clk);
        rst_n = 1'b1; en = e; load = ld; lz_blank = lz;
        seg2 = a2; seg1 = a1; seg0 = a0;
        if (!e) begin
            if (ld) begin
                m_pbuf[2] = a2; m_pbuf[1] = a1; m_pbuf[0] = a0;
                m_pend = 1'b1;
            end
            push(7'h00, 3'b000, 1'b0);
        end else begin
            np = (m_pos + 1) % (3 * DIV);
            if ((np == 0 || !m_started) && m_pend) begin
                m_act  = m_pbuf;
                m_pend = 1'b0;
            end
            m_started = 1'b1;
            if (ld) begin
                m_pbuf[2] = a2; m_pbuf[1] = a1; m_pbuf[0] = a0;
                m_pend = 1'b1;
            end
            m_pos = np;
            i = np / DIV;
            c = np % DIV;
            if (c < DIV - BLANK) begin
                b2  = lz && (m_act[2] == ZP);
                b1  = b2 && (m_act[1] == ZP);
                pat = m_act[i];
                if ((i == 2 && b2) || (i == 1 && b1)) pat = 7'h00;
                push(pat, 3'(1 << i), np == 0);
            end else begin
                push(7'h00, 3'b000, np == 0);
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, cur2, cur1, cur0, cur_lz);
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 3 * DIV + 1 && m_pos != target; k++)
            step(1'b1, 1'b0, cur2, cur1, cur0, cur_lz);
    endtask

    // Asynchronous reset asserted at a falling edge, outputs checked before
    // any clock edge can act, held across two rising edges.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_seg", 32'(seg_a), 32'h00);
        chk("rst_dig", 32'(dig_a), 32'h0);
        chk("rst_fd", 32'(fd_a), 32'h0);
        chk("rst_seg_inv", 32'(seg_b), 32'h7F);
        chk("rst_dig_inv", 32'(dig_b), 32'h7);
        chk("rst_fd_inv", 32'(fd_b), 32'h0);
        model_reset();
        push(7'h00, 3'b000, 1'b0);
        @(negedge clk);
        push(7'h00, 3'b000, 1'b0);
    endtask

    // Monitor: every rising edge presents a new output word.
    always @(posedge clk) begin
        exp_t       e;
        logic [6:0] s_inv;
        logic [2:0] d_inv;
        #1;
        if (fd_a) dut_fd++;
        if (q.size() > 0) begin
            e     = q.pop_front();
            s_inv = ~e.seg;
            d_inv = ~e.dig;
            chk("seg", 32'(seg_a), 32'(e.seg));
            chk("dig", 32'(dig_a), 32'(e.dig));
            chk("frame_done", 32'(fd_a), 32'(e.fd));
            chk("seg_inv", 32'(seg_b), 32'(s_inv));
            chk("dig_inv", 32'(dig_b), 32'(d_inv));
            chk("frame_done_inv", 32'(fd_b), 32'(e.fd));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int fd_d0, fd_m0, fd_m1;
        model_reset();
        do_reset();

        // Basic three-digit scan and frame_done cadence.
        cur2 = 7'h5B; cur1 = 7'h06; cur0 = 7'h3F; cur_lz = 1'b0;
        step(1'b0, 1'b1, cur2, cur1, cur0, cur_lz);
        fd_d0 = dut_fd;
        fd_m0 = m_fd;
        run(72);
        fd_m1 = m_fd;
        step(1'b1, 1'b0, cur2, cur1, cur0, cur_lz);
        chk("fd_count", 32'(dut_fd - fd_d0), 32'(fd_m1 - fd_m0));
        chk("fd_count_3", 32'(dut_fd - fd_d0), 32'd3);

        // Mid-frame load, then a load coinciding with the frame transfer.
        run_to(10);
        cur0 = 7'h66;
        step(1'b1, 1'b1, cur2, cur1, cur0, cur_lz);
        run_to(23);
        cur0 = 7'h7D;
        step(1'b1, 1'b1, cur2, cur1, cur0, cur_lz);
        run(50);

        // Leading-zero blanking with all digits zero.
        cur2 = ZP; cur1 = ZP; cur0 = ZP; cur_lz = 1'b1;
        step(1'b1, 1'b1, cur2, cur1, cur0, cur_lz);
        run(50);

        // Enable dropped mid-slot for five cycles.
        cur2 = 7'h4F; cur1 = 7'h6D; cur0 = 7'h07; cur_lz = 1'b0;
        step(1'b1, 1'b1, cur2, cur1, cur0, cur_lz);
        run_to(11);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, cur2, cur1, cur0, cur_lz);
        run(30);

        // Randomized traffic.
        for (int k = 0; k < 500; k++) begin
            bit e, ld;
            if (k % 50 == 0) cur_lz = 1'($urandom_range(0, 1));
            e  = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 11) == 0);
            if (ld) begin
                cur2 = ($urandom_range(0, 2) == 0) ? ZP : 7'($urandom);
                cur1 = ($urandom_range(0, 2) == 0) ? ZP : 7'($urandom);
                cur0 = ($urandom_range(0, 2) == 0) ? ZP : 7'($urandom);
            end
            if ($urandom_range(0, 199) == 0) do_reset();
            else step(e, ld, cur2, cur1, cur0, cur_lz);
        end

        // Reset asserted in the middle of the hundreds slot.
        cur2 = 7'h5B; cur1 = 7'h06; cur0 = 7'h3F; cur_lz = 1'b0;
        step(1'b1, 1'b1, cur2, cur1, cur0, cur_lz);
        run_to(2 * DIV + 5);
        do_reset();
        run(30);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
